seq_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator: captures two WIDTH-bit operands on a start handshake and scans them MSB-first, one DIGIT-bit digit per clock, stopping at the first differing digit. Supports unsigned and two's-complement modes. Supports cascade inputs for chaining to a lower-order comparator. Serves as the sequential, width-generic successor to the fixed 16-bit four-stage cascaded comparator, for datapaths where area matters more than single-cycle latency.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/digit_compare.sv | 25 ++
 rtl/seq_magnitude_comparator.sv | 149 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the sequential magnitude comparator
//
// Purpose: scan FSM state encoding, the one-hot result bundle and the digit
// count helper used to size the scan index and digits_used counter.
// Ports: none (package).

package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_compare.sv
// rtl/digit_compare.sv - combinational unsigned compare of one DIGIT-bit digit
//
// Purpose: decides the ordering of a single digit pair; the caller applies any
// sign handling before presenting the digits.
// Ports:
//   x, y    in  [DIGIT]  digits to compare
//   lt      out  x < y
//   eq      out  x == y
//   gt      out  x > y

module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-first digit-serial magnitude comparator
//
// Purpose: captures two WIDTH-bit operands on start and compares them one
// DIGIT-bit digit per clock from the top, stopping at the first differing
// digit. Equal operands fall through to the captured cascade inputs.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       request, accepted whenever not scanning
//   a, b          [WIDTH]       operands, captured on accepted start
//   signed_mode                 1 = two's-complement compare
//   cin_lt/eq/gt                cascade inputs from a lower-order comparator
//   busy                        scan in progress
//   done                        one-cycle pulse, result valid
//   lt, eq, gt                  result, held until the next done
//   digits_used   [clog2(N+1)]  digits examined for the last result

module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              signed_mode,
    input  logic                              cin_lt,
    input  logic                              cin_eq,
    input  logic                              cin_gt,
    output logic                              busy,
    output logic                              done,
    output logic                              lt,
    output logic                              eq,
    output logic                              gt,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]  digits_used
);

    localparam int N    = digit_count(WIDTH, DIGIT);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int DUW  = $clog2(N + 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
        $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end

    cmp_state_t        state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              sm_q;
    cmp_result_t       cin_q;
    cmp_result_t       res_q, res_d;
    logic [DUW-1:0]    used_q, used_d;

    logic              accept;
    logic [DIGIT-1:0]  dig_x, dig_y;
    logic              d_lt, d_eq, d_gt;

    assign accept = start && (state_q != SCAN);

    // Flipping the sign bit of the top digit maps two's-complement order onto
    // unsigned order; lower digits are plain unsigned in either mode.
    always_comb begin
        dig_x = a_q[idx_q*DIGIT +: DIGIT];
        dig_y = b_q[idx_q*DIGIT +: DIGIT];
        if (sm_q && (idx_q == IDXW'(N - 1))) begin
            dig_x[DIGIT-1] = ~dig_x[DIGIT-1];
            dig_y[DIGIT-1] = ~dig_y[DIGIT-1];
        end
    end

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .x  (dig_x),
        .y  (dig_y),
        .lt (d_lt),
        .eq (d_eq),
        .gt (d_gt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        used_d  = used_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = SCAN;
                    idx_d   = IDXW'(N - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!d_eq) begin
                    res_d   = '{lt: d_lt, eq: 1'b0, gt: d_gt};
                    used_d  = DUW'(N) - DUW'(idx_q);
                    state_d = DONE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    res_d   = cin_q;
                    used_d  = DUW'(N);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            used_q  <= used_d;
        end
    end

    // Operand capture happens only on an accepted start, so the inputs are
    // free to change for the remainder of the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sm_q  <= 1'b0;
            cin_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sm_q  <= signed_mode;
            cin_q <= '{lt: cin_lt, eq: cin_eq, gt: cin_gt};
        end
    end

    assign busy        = (state_q == SCAN);
    assign done        = (state_q == DONE);
    assign lt          = res_q.lt;
    assign eq          = res_q.eq;
    assign gt          = res_q.gt;
    assign digits_used = used_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator

module tb_seq_magnitude_comparator;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          signed_mode = 1'b0;
    logic          cin_lt = 1'b0;
    logic          cin_eq = 1'b1;
    logic          cin_gt = 1'b0;
    logic          busy, done, lt, eq, gt;
    logic [2:0]    digits_used;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .cin_lt      (cin_lt),
        .cin_eq      (cin_eq),
        .cin_gt      (cin_gt),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt),
        .digits_used (digits_used)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the result is decided by the most significant differing bit;
    // the digit holding it sets digits_used, and the numeric order of the
    // whole operands (signed or unsigned) sets lt/gt.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic msm, input logic [2:0] mcin,
                                  output logic [2:0] res, output int used);
        logic [W-1:0] diff;
        int hi;
        diff = ma ^ mb;
        hi = -1;
        for (int i = 0; i < W; i++) if (diff[i]) hi = i;
        if (hi < 0) begin
            res  = mcin;
            used = N;
        end else begin
            used = N - hi / D;
            if (msm) res = ($signed(ma) < $signed(mb)) ? 3'b100 : 3'b001;
            else     res = (ma < mb) ? 3'b100 : 3'b001;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tsm, input logic [2:0] tcin);
        a = ta;
        b = tb_v;
        signed_mode = tsm;
        {cin_lt, cin_eq, cin_gt} = tcin;
        start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = ~tsm;
        {cin_lt, cin_eq, cin_gt} = ~tcin;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
    endtask

    task automatic wait_done(input string tag, input logic [2:0] exp_res, input int exp_used);
        while (!done && (cyc - t0) < N + 3) @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, cyc - t0, exp_used);
        check({tag, "_result"}, {lt, eq, gt}, exp_res);
        check({tag, "_digits"}, digits_used, exp_used);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsm, input logic [2:0] tcin);
        logic [2:0] er;
        int eu;
        model(ta, tb_v, tsm, tcin, er, eu);
        start_op(ta, tb_v, tsm, tcin);
        wait_done(tag, er, eu);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
        check({tag, "_held"}, {lt, eq, gt}, er);
    endtask

    initial begin
        logic [2:0] er1, er2;
        int eu1, eu2;
        logic saw;
        logic [W-1:0] ra, rb;
        logic rsm;
        logic [2:0] rcin;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", {lt, eq, gt}, 0);
        check("rst_digits", digits_used, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1_lt",     16'h1234, 16'h1235, 1'b0, 3'b010);
        run_op("t2_gt",     16'h9000, 16'h1FFF, 1'b0, 3'b010);
        run_op("t3_signed", 16'h8000, 16'h0001, 1'b1, 3'b010);
        run_op("t4_unsign", 16'h8000, 16'h0001, 1'b0, 3'b010);
        run_op("t5_cascade",16'hABCD, 16'hABCD, 1'b0, 3'b001);
        run_op("t6_equal",  16'h0F0F, 16'h0F0F, 1'b1, 3'b010);

        // Start during SCAN ignored, then back-to-back start during DONE.
        model(16'h5555, 16'h5556, 1'b0, 3'b010, er1, eu1);
        model(16'h7000, 16'h1234, 1'b0, 3'b010, er2, eu2);
        start_op(16'h5555, 16'h5556, 1'b0, 3'b010);
        a = 16'h0000;
        b = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t7_ignore", er1, eu1);
        start_op(16'h7000, 16'h1234, 1'b0, 3'b010);
        check("t8_first_held", {lt, eq, gt}, er1);
        wait_done("t8_b2b", er2, eu2);
        @(negedge clk);

        // Asynchronous reset on the second SCAN cycle aborts the scan.
        start_op(16'hABCD, 16'hABCD, 1'b0, 3'b010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t9_rst_busy", busy, 0);
        check("t9_rst_done", done, 0);
        check("t9_rst_result", {lt, eq, gt}, 0);
        check("t9_rst_digits", digits_used, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("t9_no_done", saw, 0);
        run_op("t10_after_rst", 16'h00FF, 16'h0100, 1'b0, 3'b010);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = ra ^ W'($urandom_range(1, 15) << (D * $urandom_range(0, N - 1)));
            endcase
            rsm = 1'($urandom);
            rcin = 3'b001 << $urandom_range(0, 2);
            run_op("rnd", ra, rb, rsm, rcin);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
